// File: rtl/hazard_controller.sv
// Decode-stage hazard controller: per-register pending-write counters for the
// scalar and vector files, RAW/WAW stall detection and post-branch flush sequencing.
`default_nettype none

module hazard_controller #(
  parameter int WB_LAT    = 3,
  parameter int FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src_a,
  input  logic [3:0]  id_src_b,
  input  logic        id_use_a,
  input  logic        id_use_b,
  input  logic        id_src_a_vec,
  input  logic        id_src_b_vec,
  input  logic [3:0]  id_RegToWrite,
  input  logic        id_RegWriteEnSc,
  input  logic        id_RegWriteEnVec,
  input  logic        ex_branch_taken,
  output logic        issue,
  output logic        stall,
  output logic        flush,
  output logic [15:0] busy_sc,
  output logic [15:0] busy_vec,
  output logic [15:0] stall_count
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [2:0] WB_LOAD    = 3'(WB_LAT);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC);

  logic [0:0]  state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [2:0]  cnt_sc_q  [16];
  logic [2:0]  cnt_sc_d  [16];
  logic [2:0]  cnt_vec_q [16];
  logic [2:0]  cnt_vec_d [16];
  logic [15:0] stall_count_q, stall_count_d;

  logic busy_a, busy_b, waw, hazard;

  // Hazard detection: each source looks only in its own register file.
  always_comb begin
    busy_a = id_src_a_vec ? (cnt_vec_q[id_src_a] != 3'd0) : (cnt_sc_q[id_src_a] != 3'd0);
    busy_b = id_src_b_vec ? (cnt_vec_q[id_src_b] != 3'd0) : (cnt_sc_q[id_src_b] != 3'd0);
    waw    = (id_RegWriteEnSc  && (cnt_sc_q[id_RegToWrite]  != 3'd0)) ||
             (id_RegWriteEnVec && (cnt_vec_q[id_RegToWrite] != 3'd0));
    hazard = (id_use_a && busy_a) || (id_use_b && busy_b) || waw;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      fcnt_q        <= 3'd0;
      stall_count_q <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        cnt_sc_q[i]  <= 3'd0;
        cnt_vec_q[i] <= 3'd0;
      end
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      stall_count_q <= stall_count_d;
      for (int i = 0; i < 16; i++) begin
        cnt_sc_q[i]  <= cnt_sc_d[i];
        cnt_vec_q[i] <= cnt_vec_d[i];
      end
    end
  end

  // Next-state logic; a branch taken during FLUSH restarts the count.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (ex_branch_taken) begin
      state_d = ST_FLUSH;
      fcnt_d  = FLUSH_LOAD;
    end else if (state_q == ST_FLUSH) begin
      if (fcnt_q == 3'd1) begin
        state_d = ST_RUN;
        fcnt_d  = 3'd0;
      end else begin
        fcnt_d = fcnt_q - 3'd1;
      end
    end
  end

  // Output logic, forced low while reset is held regardless of clk.
  always_comb begin
    flush = rst && (ex_branch_taken || (state_q == ST_FLUSH));
    stall = rst && id_valid && hazard && !flush;
    issue = rst && id_valid && !hazard && !flush;
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cnt_sc_d[i]  = (cnt_sc_q[i]  != 3'd0) ? cnt_sc_q[i]  - 3'd1 : 3'd0;
      cnt_vec_d[i] = (cnt_vec_q[i] != 3'd0) ? cnt_vec_q[i] - 3'd1 : 3'd0;
      if (issue && id_RegWriteEnSc && (id_RegToWrite == 4'(i)))
        cnt_sc_d[i] = WB_LOAD;
      if (issue && id_RegWriteEnVec && (id_RegToWrite == 4'(i)))
        cnt_vec_d[i] = WB_LOAD;
      busy_sc[i]  = (cnt_sc_q[i]  != 3'd0);
      busy_vec[i] = (cnt_vec_q[i] != 3'd0);
    end
    stall_count_d = (stall && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1
                                                           : stall_count_q;
  end

  assign stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// Directed, table-driven check of hazard_controller with default parameters.
`default_nettype none

module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [3:0]  id_src_a = 4'd0;
  logic [3:0]  id_src_b = 4'd0;
  logic        id_use_a = 1'b0;
  logic        id_use_b = 1'b0;
  logic        id_src_a_vec = 1'b0;
  logic        id_src_b_vec = 1'b0;
  logic [3:0]  id_RegToWrite = 4'd0;
  logic        id_RegWriteEnSc = 1'b0;
  logic        id_RegWriteEnVec = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic        issue, stall, flush;
  logic [15:0] busy_sc, busy_vec, stall_count;

  int total = 0;
  int bad   = 0;

  hazard_controller #(.WB_LAT(3), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b),
    .id_src_a_vec(id_src_a_vec), .id_src_b_vec(id_src_b_vec),
    .id_RegToWrite(id_RegToWrite), .id_RegWriteEnSc(id_RegWriteEnSc),
    .id_RegWriteEnVec(id_RegWriteEnVec), .ex_branch_taken(ex_branch_taken),
    .issue(issue), .stall(stall), .flush(flush),
    .busy_sc(busy_sc), .busy_vec(busy_vec), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  sa, sb;
    logic        ua, ub, av, bv;
    logic [3:0]  dst;
    logic        wsc, wvec, br;
    logic        e_iss, e_stl, e_fl;
    logic [15:0] e_bsc, e_bvec, e_cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic v, input logic [3:0] sa, input logic [3:0] sb,
    input logic ua, input logic ub, input logic av, input logic bv,
    input logic [3:0] dst, input logic wsc, input logic wvec, input logic br,
    input logic e_iss, input logic e_stl, input logic e_fl,
    input logic [15:0] e_bsc, input logic [15:0] e_bvec, input logic [15:0] e_cnt);
    vec_t t;
    t.v = v; t.sa = sa; t.sb = sb; t.ua = ua; t.ub = ub; t.av = av; t.bv = bv;
    t.dst = dst; t.wsc = wsc; t.wvec = wvec; t.br = br;
    t.e_iss = e_iss; t.e_stl = e_stl; t.e_fl = e_fl;
    t.e_bsc = e_bsc; t.e_bvec = e_bvec; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, k, act, exp);
    end
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_src_a = 4'd0; id_src_b = 4'd0; id_use_a = 1'b0; id_use_b = 1'b0;
    id_src_a_vec = 1'b0; id_src_b_vec = 1'b0; id_RegToWrite = 4'd0;
    id_RegWriteEnSc = 1'b0; id_RegWriteEnVec = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic chk_all_zero(input int k);
    chk("rst_issue", k, int'(issue), 0);
    chk("rst_stall", k, int'(stall), 0);
    chk("rst_flush", k, int'(flush), 0);
    chk("rst_busy_sc", k, int'(busy_sc), 0);
    chk("rst_busy_vec", k, int'(busy_vec), 0);
    chk("rst_stall_count", k, int'(stall_count), 0);
  endtask

  vec_t tv [24];

  initial begin
    //        v sa sb ua ub av bv dst wsc wv br  iss stl fl  bsc      bvec     cnt
    tv[0]  = mk(1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0);
    tv[1]  = mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0004, 16'h0000, 0);
    tv[2]  = mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0004, 16'h0000, 1);
    tv[3]  = mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0004, 16'h0000, 2);
    tv[4]  = mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 3);
    tv[5]  = mk(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 3);
    tv[6]  = mk(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0020, 16'h0000, 3);
    tv[7]  = mk(1, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1, 0, 0, 16'h0020, 16'h0000, 3);
    tv[8]  = mk(1, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 1, 0, 16'h0020, 16'h0080, 3);
    tv[9]  = mk(1, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 1, 0, 16'h0000, 16'h0080, 4);
    tv[10] = mk(1, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 1, 0, 16'h0000, 16'h0080, 5);
    tv[11] = mk(1, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 6);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0080, 6);
    tv[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0000, 16'h0080, 6);
    tv[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0000, 16'h0080, 6);
    tv[15] = mk(1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 6);
    tv[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 6);
    tv[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 6);
    tv[18] = mk(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 6);
    tv[19] = mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0008, 16'h0000, 6);
    tv[20] = mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0008, 16'h0000, 7);
    tv[21] = mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 16'h0000, 7);
    tv[22] = mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 7);
    tv[23] = mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 7);

    // Reset held with hostile inputs: everything must read zero.
    rst = 1'b0;
    id_valid = 1'b1; ex_branch_taken = 1'b1; id_RegWriteEnSc = 1'b1; id_RegToWrite = 4'd1;
    repeat (2) @(negedge clk);
    chk_all_zero(-1);
    drive_idle();
    rst = 1'b1;

    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      id_valid = tv[k].v; id_src_a = tv[k].sa; id_src_b = tv[k].sb;
      id_use_a = tv[k].ua; id_use_b = tv[k].ub;
      id_src_a_vec = tv[k].av; id_src_b_vec = tv[k].bv;
      id_RegToWrite = tv[k].dst; id_RegWriteEnSc = tv[k].wsc;
      id_RegWriteEnVec = tv[k].wvec; ex_branch_taken = tv[k].br;
      @(negedge clk);
      chk("issue", k, int'(issue), int'(tv[k].e_iss));
      chk("stall", k, int'(stall), int'(tv[k].e_stl));
      chk("flush", k, int'(flush), int'(tv[k].e_fl));
      chk("busy_sc", k, int'(busy_sc), int'(tv[k].e_bsc));
      chk("busy_vec", k, int'(busy_vec), int'(tv[k].e_bvec));
      chk("stall_count", k, int'(stall_count), int'(tv[k].e_cnt));
    end

    // Reset asserted mid-flush with a scalar write still pending.
    @(posedge clk); #1;
    drive_idle();
    id_valid = 1'b1; id_RegWriteEnSc = 1'b1; id_RegToWrite = 4'd4;
    @(negedge clk);
    chk("mf_issue_wr", 100, int'(issue), 1);
    @(posedge clk); #1;
    drive_idle();
    id_valid = 1'b1; ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("mf_flush_br", 101, int'(flush), 1);
    @(posedge clk); #1;
    ex_branch_taken = 1'b0;
    #1;
    chk("mf_flush_state", 102, int'(flush), 1);
    chk("mf_busy_pend", 102, int'(busy_sc), 16'h0010);
    rst = 1'b0;
    #1;
    chk_all_zero(103);
    @(posedge clk); #1;
    chk_all_zero(104);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_issue", 105, int'(issue), 1);
    chk("post_rst_flush", 105, int'(flush), 0);
    chk("post_rst_stall", 105, int'(stall), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
